// File: rtl/mult_share_arbiter_if.sv
// Bundle of request, multiplier and response signals for mult_share_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding logic.
interface mult_share_arbiter_if #(
  parameter int WIDTH = 28,
  parameter int CNTW  = 16
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [WIDTH-1:0]     req0_a;
  logic [WIDTH-1:0]     req0_b;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [WIDTH-1:0]     req1_a;
  logic [WIDTH-1:0]     req1_b;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   mul_p;
  logic                 rsp0_valid;
  logic                 rsp1_valid;
  logic [2*WIDTH-1:0]   rsp_data;
  logic [CNTW-1:0]      done0_cnt;
  logic [CNTW-1:0]      done1_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p,
    output req0_ready, req1_ready, mul_a, mul_b,
           rsp0_valid, rsp1_valid, rsp_data, done0_cnt, done1_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_p,
    input  req0_ready, req1_ready, mul_a, mul_b,
           rsp0_valid, rsp1_valid, rsp_data, done0_cnt, done1_cnt
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one registered multiplier between two requesters,
// with owner tags carried alongside the multiplier latency.
module mult_share_arbiter #(
  parameter int WIDTH = 28,
  parameter int LAT   = 1,
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  mult_share_arbiter_if.slave bus
);

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [LAT:0]      tag_vld;
  logic [LAT:0]      tag_id;
  logic              rsp0_q;
  logic              rsp1_q;
  logic [CNTW-1:0]   cnt0_q;
  logic [CNTW-1:0]   cnt1_q;

  // Grants are built from the valids and last_grant only, never from a ready.
  always_comb begin
    grant0 = rstn & bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1 = rstn & bus.req1_valid & (~bus.req0_valid | ~last_grant);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.rsp_data   = bus.mul_p;
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.done0_cnt  = cnt0_q;
  assign bus.done1_cnt  = cnt1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      tag_vld    <= '0;
      tag_id     <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      if (grant0) begin
        a_q        <= bus.req0_a;
        b_q        <= bus.req0_b;
        last_grant <= 1'b0;
      end else if (grant1) begin
        a_q        <= bus.req1_a;
        b_q        <= bus.req1_b;
        last_grant <= 1'b1;
      end
      // Tag pipe never stalls; bubbles ride along as tag_vld=0.
      tag_vld <= {tag_vld[LAT-1:0], grant0 | grant1};
      tag_id  <= {tag_id[LAT-1:0], grant1};
      // Registered response lines up with the multiplier's extra output stage.
      rsp0_q  <= tag_vld[LAT] & ~tag_id[LAT];
      rsp1_q  <= tag_vld[LAT] &  tag_id[LAT];
      if (rsp0_q) cnt0_q <= cnt0_q + {{(CNTW-1){1'b0}}, 1'b1};
      if (rsp1_q) cnt1_q <= cnt1_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule
